srrc_sym_slicer: RTL
====================

// Module: srrc_sym_slicer
// PURPOSE
//  Symbol-rate sampler and 4-ASK decision device placed directly downstream of srrc_gold_rx_flt.
//  Picks one of four samples per symbol, slices it against an adaptively tracked reference level,
//  and outputs the symbol code, the decided level and the slicer error.
//  Feeds the symbol demapper and the MER/loop logic.
// PARAMETERS
//  SAMPLE_PHASE  2'd0      sample index within symbol (0..3, counted from sym_clk_en) to capture
//  LOG2_AVG      4         reference averaging window = 2^LOG2_AVG symbols
//  INIT_REF      18'sd32768  reference (mean |x|, 1s17) used until first window completes (=0.25)
// PORTS
//  sys_clk     in   1   system clock (25 MHz); all logic on posedge
//  reset       in   1   synchronous, active-low reset
//  sam_clk_en  in   1   one-cycle sample-rate enable from clk_gen
//  sym_clk_en  in   1   one-cycle symbol-rate enable from clk_gen (coincides with a sam_clk_en)
//  rx_in       in   18  signed 1s17 matched-filter output
//  sym_valid   out  1   one-cycle pulse: outputs below updated this cycle
//  sym_code    out  2   decision: 00=-3a, 01=-a, 10=+a, 11=+3a
//  sym_level   out  18  signed decided level (±ref/2, ±3ref/2)
//  slc_err     out  18  signed rx sample minus sym_level, saturated to 18 bits
//  ref_level   out  18  current reference (mean |x|, unsigned magnitude held in signed 18)
//  locked      out  1   high once first averaging window completed
//  err_pow     out  36  windowed sum of slc_err^2 (SLICER_MER_EN only; else 0)
// BEHAVIOUR
//  Reset (reset==0 at posedge): sym_valid=0, sym_code=2'b10, sym_level=0, slc_err=0,
//   ref_level=INIT_REF, locked=0, err_pow=0, phase counter=0, accumulator=0, symbol count=0, state=ACQ.
//  Reset mid-window discards the partial window; no output pulses during reset.
//  Phase counter: cleared to 0 on sym_clk_en, else +1 on sam_clk_en; wraps 3->0.
//  Capture: on sam_clk_en with (counter==SAMPLE_PHASE), or sym_clk_en when SAMPLE_PHASE==0.
//   rx_in is registered.
//  Latency: sym_valid and all decision outputs asserted exactly 1 sys_clk after capture cycle.
//  Thresholds (x = captured sample, r = ref_level):
//   x >= r -> 11; 0 <= x < r -> 10; -r <= x < 0 -> 01; x < -r -> 00.
//   Ties resolve upward (x==0 -> 10, x==r -> 11, x==-r -> 01).
//  sym_level = ±(r>>1) inner, ±(r + (r>>1)) outer; slc_err = x - sym_level, saturate to ±(2^17-1)/-2^17.
//  Averaging: |x| (18-bit unsigned; |-2^17| = 2^17 exact) added to (18+LOG2_AVG)-bit accumulator per capture.
//   After 2^LOG2_AVG captures:
//   ref_level <= acc>>LOG2_AVG, effective on next capture's decision; acc and count clear same cycle.
//   No overflow possible by width.
//  FSM: ACQ (locked=0, uses INIT_REF) -> TRACK on first window end (locked=1);
//   TRACK stays until reset. Window-end capture is sliced with old ref.
//  sam/sym enables arriving while not capturing have no effect; rx_in ignored outside capture.
// CONFIGURATION
//  SLICER_MER_EN defined:
//   adds slc_err^2 accumulator (36 b, saturating at all-ones) over same window;
//   err_pow updated at window end with sum, held otherwise.
//  SLICER_MER_EN undefined: no squarer/accumulator, err_pow tied 36'd0.
// STRUCTURE
//  defines.vh: symbol codes (SYM_M3..SYM_P3), SYMBOL_P2-style level constants, FSM state encodings.
//  Sub-module slicer_mag_avg: |x| accumulate, window count, ref update, window_done pulse.
//  Top: phase counter, capture, compare/level/error logic, FSM, optional MER path.
// TESTING (SAMPLE_PHASE=0, LOG2_AVG=4, INIT_REF=32768)
//  Reset held low 3 cycles mid-stream -> all outputs at reset values, sym_valid never pulses.
//  rx_in=49152 at capture -> next cycle sym_code=11, sym_level=49152, slc_err=0.
//  rx_in=0 / 32768 / -32768 -> codes 10 / 11 / 01 (tie rules).
//  16 captures alternating 49152,16384 -> locked rises after 16th, ref_level stays 32768.
//  16 captures all +65536 -> ref_level=65536. Next rx_in=98304 -> code 11, slc_err=0.
//  rx_in=-131072 with ref=32768 -> code 00, slc_err=-81920.
//   With SLICER_MER_EN, err_pow equals bench-computed sum of squares.

Source files
------------

// File: rtl/srrc_sym_slicer_pkg.sv
// Shared symbol codes, FSM states and saturation helper for the 4-ASK symbol slicer.
package srrc_sym_slicer_pkg;

  localparam int DW = 18;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b10;
  localparam logic [1:0] SYM_P3 = 2'b11;

  localparam logic signed [DW-1:0] ERR_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] ERR_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {
    ST_ACQ   = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Clamp a (DW+2)-bit signed difference into DW-bit signed range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+1:0] v);
    if ((v[DW+1:DW-1] == 3'b000) || (v[DW+1:DW-1] == 3'b111)) return v[DW-1:0];
    else if (v[DW+1]) return ERR_MIN;
    else return ERR_MAX;
  endfunction

endpackage

// File: rtl/srrc_sym_slicer_mag_avg.sv
// Reference tracker: accumulates |x| over 2^LOG2_AVG captures and publishes the mean.
// o_window_done is a same-cycle pulse on the capture that closes a window.
import srrc_sym_slicer_pkg::*;

module srrc_sym_slicer_mag_avg #(
  parameter int              LOG2_AVG = 4,
  parameter logic [DW-1:0]   INIT_REF = 18'd32768
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_capture,
  input  logic signed [DW-1:0] i_x,
  output logic        [DW-1:0] o_ref,
  output logic                 o_window_done
);

  localparam int AW = DW + LOG2_AVG;

  logic [AW-1:0]       r_acc;
  logic [LOG2_AVG-1:0] r_cnt;
  logic [DW-1:0]       r_ref;
  logic [DW-1:0]       w_mag;
  logic [AW-1:0]       w_sum;

  // |-2^17| maps to 2^17, which still fits an 18-bit unsigned magnitude.
  assign w_mag         = i_x[DW-1] ? (~i_x + 18'd1) : i_x;
  assign w_sum         = r_acc + AW'(w_mag);
  assign o_window_done = i_capture && (r_cnt == '1);
  assign o_ref         = r_ref;

  // Window accumulation and reference update on the closing capture.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ref <= INIT_REF;
    end else if (i_capture) begin
      if (o_window_done) begin
        r_ref <= w_sum[AW-1:LOG2_AVG];
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/srrc_sym_slicer.sv
// Symbol-rate sampler and 4-ASK slicer with adaptive reference.
// Optional macro SLICER_MER_EN adds a windowed slicer-error power accumulator.
import srrc_sym_slicer_pkg::*;

module srrc_sym_slicer #(
  parameter logic [1:0]             SAMPLE_PHASE = 2'd0,
  parameter int                     LOG2_AVG     = 4,
  parameter logic signed [DW-1:0]   INIT_REF     = 18'sd32768
) (
  input  logic                 i_sys_clk,
  input  logic                 i_reset,
  input  logic                 i_sam_clk_en,
  input  logic                 i_sym_clk_en,
  input  logic signed [DW-1:0] i_rx_in,
  output logic                 o_sym_valid,
  output logic [1:0]           o_sym_code,
  output logic signed [DW-1:0] o_sym_level,
  output logic signed [DW-1:0] o_slc_err,
  output logic signed [DW-1:0] o_ref_level,
  output logic                 o_locked,
  output logic [2*DW-1:0]      o_err_pow
);

  logic [1:0]             r_phase;
  logic [1:0]             w_idx;
  logic                   w_capture;
  logic [DW-1:0]          w_ref;
  logic                   w_window_done;
  state_t                 r_state, w_state_nxt;

  logic signed [DW+1:0]   w_x, w_r, w_half, w_outer, w_level, w_err;
  logic [1:0]             w_code;
  logic signed [DW-1:0]   w_err_sat;

  // Index of the sample arriving this cycle: 0 on the symbol enable, else previous + 1.
  assign w_idx     = i_sym_clk_en ? 2'd0 : (r_phase + 2'd1);
  assign w_capture = (i_sym_clk_en || i_sam_clk_en) && (w_idx == SAMPLE_PHASE);

  // Sample phase counter.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset)          r_phase <= 2'd0;
    else if (i_sym_clk_en) r_phase <= 2'd0;
    else if (i_sam_clk_en) r_phase <= r_phase + 2'd1;
  end

  srrc_sym_slicer_mag_avg #(
    .LOG2_AVG (LOG2_AVG),
    .INIT_REF (INIT_REF)
  ) u_mag_avg (
    .i_clk         (i_sys_clk),
    .i_reset       (i_reset),
    .i_capture     (w_capture),
    .i_x           (i_rx_in),
    .o_ref         (w_ref),
    .o_window_done (w_window_done)
  );

  assign o_ref_level = w_ref;

  // Decision, level and error against the reference in force before this capture.
  always_comb begin
    w_x     = {{2{i_rx_in[DW-1]}}, i_rx_in};
    w_r     = {2'b00, w_ref};
    w_half  = {3'b000, w_ref[DW-1:1]};
    w_outer = w_r + w_half;
    w_code  = SYM_P1;
    w_level = w_half;
    if (w_x >= w_r) begin
      w_code  = SYM_P3;
      w_level = w_outer;
    end else if (w_x >= 20'sd0) begin
      w_code  = SYM_P1;
      w_level = w_half;
    end else if (w_x >= -w_r) begin
      w_code  = SYM_M1;
      w_level = -w_half;
    end else begin
      w_code  = SYM_M3;
      w_level = -w_outer;
    end
    w_err     = w_x - w_level;
    w_err_sat = sat_dw(w_err);
  end

  // FSM state register.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset) r_state <= ST_ACQ;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: first completed window locks for good.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_ACQ) && w_window_done) w_state_nxt = ST_TRACK;
  end

  assign o_locked = (r_state == ST_TRACK);

  // Decision output registers, updated one cycle after capture.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset) begin
      o_sym_valid <= 1'b0;
      o_sym_code  <= SYM_P1;
      o_sym_level <= '0;
      o_slc_err   <= '0;
    end else begin
      o_sym_valid <= w_capture;
      if (w_capture) begin
        o_sym_code  <= w_code;
        o_sym_level <= w_level[DW-1:0];
        o_slc_err   <= w_err_sat;
      end
    end
  end

`ifdef SLICER_MER_EN
  logic signed [2*DW-1:0] w_sq;
  logic [2*DW:0]          w_mer_sum;
  logic [2*DW-1:0]        w_mer_sat;
  logic [2*DW-1:0]        r_mer_acc;
  logic [2*DW-1:0]        r_err_pow;

  assign w_sq      = w_err_sat * w_err_sat;
  assign w_mer_sum = {1'b0, r_mer_acc} + {1'b0, w_sq};
  assign w_mer_sat = w_mer_sum[2*DW] ? '1 : w_mer_sum[2*DW-1:0];
  assign o_err_pow = r_err_pow;

  // Saturating error-power accumulation, published at window end.
  always_ff @(posedge i_sys_clk) begin
    if (!i_reset) begin
      r_mer_acc <= '0;
      r_err_pow <= '0;
    end else if (w_capture) begin
      if (w_window_done) begin
        r_err_pow <= w_mer_sat;
        r_mer_acc <= '0;
      end else begin
        r_mer_acc <= w_mer_sat;
      end
    end
  end
`else
  assign o_err_pow = '0;
`endif

endmodule
